// File: rtl/adt7420_pkg.sv
// Shared types and constants for the ADT7420 I2C target emulator.
package adt7420_pkg;

    localparam int unsigned TEMP_W = 13;
    localparam int unsigned PTR_W  = 4;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h4B;
    localparam logic [7:0] ID_VALUE_DEFAULT = 8'hCB;

    localparam logic [PTR_W-1:0] REG_TEMP_MSB = 4'h0;
    localparam logic [PTR_W-1:0] REG_TEMP_LSB = 4'h1;
    localparam logic [PTR_W-1:0] REG_STATUS   = 4'h2;
    localparam logic [PTR_W-1:0] REG_CONFIG   = 4'h3;
    localparam logic [PTR_W-1:0] REG_ID       = 4'hB;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_WPTR,
        ST_ACK_W,
        ST_WDATA,
        ST_RDATA,
        ST_RACK,
        ST_IDLE_WAIT
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/adt7420_i2c_target_sync.sv
// SCL/SDA synchronizer, optional 3-sample majority filter (GLITCH_FILTER_EN), and
// registered edge / START / STOP detection.
module i2c_line_sync
    import adt7420_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       w_scl;
    logic       w_sda;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       r_scl_rise;
    logic       r_scl_fall;
    logic       r_start;
    logic       r_stop;
    logic       r_sda_s;

    // Idle bus is high, so reset to 1 to avoid phantom edges
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_in};
            r_sda_sync <= {r_sda_sync[0], sda_in};
        end
    end

`ifdef GLITCH_FILTER_EN
    logic [1:0] r_scl_hist;
    logic [1:0] r_sda_hist;
    logic       r_scl_filt;
    logic       r_sda_filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
            r_scl_filt <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
            r_sda_filt <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
        end
    end

    assign w_scl = r_scl_filt;
    assign w_sda = r_sda_filt;
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_sda_s    <= 1'b1;
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
            r_scl_rise <= w_scl & ~r_scl_prev;
            r_scl_fall <= ~w_scl & r_scl_prev;
            r_start    <= r_sda_prev & ~w_sda & w_scl & r_scl_prev;
            r_stop     <= ~r_sda_prev & w_sda & w_scl & r_scl_prev;
            r_sda_s    <= w_sda;
        end
    end

    assign scl_rise  = r_scl_rise;
    assign scl_fall  = r_scl_fall;
    assign start_det = r_start;
    assign stop_det  = r_stop;
    assign sda_s     = r_sda_s;

endmodule

// File: rtl/adt7420_i2c_target.sv
// I2C target emulating the ADT7420 register interface (temp, status, config, ID).
// Define GLITCH_FILTER_EN to enable majority filtering of SCL/SDA.
module adt7420_i2c_target
    import adt7420_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter logic [7:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_drive_low,
    input  logic [TEMP_W-1:0] temp_in,
    output logic [7:0]        cfg_reg,
    output logic              busy
);

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda_s;

    i2c_line_sync u_sync (
        .clk       (CLK100MHZ),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sda_s)
    );

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_drive, w_drive_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [7:0]         r_cfg, w_cfg_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_ack_on, w_ack_on_nxt;
    logic               r_rw, w_rw_nxt;
    logic [TEMP_W-1:0]  r_shadow, w_shadow_nxt;
    logic [7:0]         w_byte;
    logic [7:0]         w_rd_data;

    always_comb begin
        w_rd_data = 8'h00;
        case (r_ptr)
            REG_TEMP_MSB: w_rd_data = r_shadow[12:5];
            REG_TEMP_LSB: w_rd_data = {r_shadow[4:0], 3'b000};
            REG_STATUS:   w_rd_data = 8'h00;
            REG_CONFIG:   w_rd_data = r_cfg;
            REG_ID:       w_rd_data = ID_VALUE;
            default:      w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_shift  <= 8'h00;
            r_drive  <= 1'b0;
            r_ptr    <= 4'h0;
            r_cfg    <= 8'h00;
            r_busy   <= 1'b0;
            r_ack_on <= 1'b0;
            r_rw     <= 1'b0;
            r_shadow <= 13'h0000;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_drive  <= w_drive_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cfg    <= w_cfg_nxt;
            r_busy   <= w_busy_nxt;
            r_ack_on <= w_ack_on_nxt;
            r_rw     <= w_rw_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

    // r_ack_on marks the first half of a two-fall ACK window (drive, then release)
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_drive_nxt  = r_drive;
        w_ptr_nxt    = r_ptr;
        w_cfg_nxt    = r_cfg;
        w_busy_nxt   = r_busy;
        w_ack_on_nxt = r_ack_on;
        w_rw_nxt     = r_rw;
        w_shadow_nxt = r_shadow;
        w_byte       = {r_shift[6:0], w_sda_s};

        if (w_start) begin
            w_state_nxt  = ST_ADDR;
            w_cnt_nxt    = 4'd0;
            w_drive_nxt  = 1'b0;
            w_shadow_nxt = temp_in;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_drive_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            if (w_byte[7:1] == DEV_ADDR) begin
                                w_busy_nxt   = 1'b1;
                                w_rw_nxt     = w_byte[0];
                                w_ack_on_nxt = 1'b0;
                                w_state_nxt  = ST_ACK_A;
                            end else begin
                                w_busy_nxt  = 1'b0;
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
                ST_ACK_A: begin
                    if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            w_drive_nxt  = 1'b1;
                            w_ack_on_nxt = 1'b1;
                        end else if (r_rw) begin
                            w_state_nxt = ST_RDATA;
                            w_cnt_nxt   = 4'd0;
                            w_shift_nxt = {w_rd_data[6:0], 1'b0};
                            w_drive_nxt = ~w_rd_data[7];
                        end else begin
                            w_state_nxt = ST_WPTR;
                            w_cnt_nxt   = 4'd0;
                            w_drive_nxt = 1'b0;
                        end
                    end
                end
                ST_WPTR, ST_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            if (r_state == ST_WPTR) begin
                                w_ptr_nxt = w_byte[3:0];
                            end else begin
                                if (r_ptr == REG_CONFIG) begin
                                    w_cfg_nxt = w_byte;
                                end
                                w_ptr_nxt = r_ptr + 4'd1;
                            end
                            w_ack_on_nxt = 1'b0;
                            w_state_nxt  = ST_ACK_W;
                        end
                    end
                end
                ST_ACK_W: begin
                    if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            w_drive_nxt  = 1'b1;
                            w_ack_on_nxt = 1'b1;
                        end else begin
                            w_drive_nxt = 1'b0;
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_drive_nxt  = 1'b0;
                            w_ack_on_nxt = 1'b0;
                            w_state_nxt  = ST_RACK;
                        end else begin
                            w_drive_nxt = ~r_shift[7];
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                ST_RACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda_s) begin
                            w_ptr_nxt    = r_ptr + 4'd1;
                            w_ack_on_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE_WAIT;
                        end
                    end else if (w_scl_fall && r_ack_on) begin
                        w_state_nxt = ST_RDATA;
                        w_cnt_nxt   = 4'd0;
                        w_shift_nxt = {w_rd_data[6:0], 1'b0};
                        w_drive_nxt = ~w_rd_data[7];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sda_drive_low = r_drive;
    assign cfg_reg       = r_cfg;
    assign busy          = r_busy;

endmodule

// File: tb/tb_adt7420_i2c_target.sv
// Directed bench: bit-banged I2C master against adt7420_i2c_target.
module tb_adt7420_i2c_target;

    localparam int unsigned Q = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        scl_m;
    logic        sda_m;
    logic [12:0] temp_in;
    logic        sda_drive_low;
    logic [7:0]  cfg_reg;
    logic        busy;
    logic        sda_line;
    int          n_total;
    int          n_bad;
    logic        drv_seen;
    logic        busy_seen;

    assign sda_line = sda_m & ~sda_drive_low;

    adt7420_i2c_target dut (
        .CLK100MHZ     (clk),
        .reset         (reset),
        .scl_in        (scl_m),
        .sda_in        (sda_line),
        .sda_drive_low (sda_drive_low),
        .temp_in       (temp_in),
        .cfg_reg       (cfg_reg),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wq();
        repeat (Q) begin
            @(negedge clk);
            if (sda_drive_low) drv_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic wr_bit(input logic b, input logic glitch);
        sda_m = b; wq();
        scl_m = 1'b1; wq();
        if (glitch) begin
            @(negedge clk); sda_m = ~b;
            @(negedge clk); sda_m = b;
        end
        wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic rd_bit(output logic b);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        b = sda_line; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic wr_byte(input logic [7:0] d, input int gidx, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i], i == gidx);
        rd_bit(ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(nack, 1'b0);
    endtask

    // START, address+W, pointer, repeated START, address+R; returns the three ACK bits
    task automatic open_read(input logic [7:0] p, output logic [2:0] acks);
        i2c_start();
        wr_byte(8'h96, -1, acks[2]);
        wr_byte(p, -1, acks[1]);
        i2c_start();
        wr_byte(8'h97, -1, acks[0]);
    endtask

    task automatic test_reset();
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; temp_in = 13'h0190;
        repeat (5) @(negedge clk);
        n_total++; if (sda_drive_low !== 1'b0) begin n_bad++; $display("FAIL reset_sda got=%b exp=0", sda_drive_low); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_total++; if (cfg_reg !== 8'h00) begin n_bad++; $display("FAIL reset_cfg got=%h exp=00", cfg_reg); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_read_temp();
        logic [2:0] acks;
        logic [7:0] d0, d1;
        temp_in = 13'h0190;
        open_read(8'h00, acks);
        n_total++; if (acks !== 3'b000) begin n_bad++; $display("FAIL rt_acks got=%b exp=000", acks); end
        rd_byte(1'b0, d0);
        rd_byte(1'b1, d1);
        n_total++; if (d0 !== 8'h0C) begin n_bad++; $display("FAIL rt_msb got=%h exp=0c", d0); end
        n_total++; if (d1 !== 8'h80) begin n_bad++; $display("FAIL rt_lsb got=%h exp=80", d1); end
        n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rt_busy_before_stop got=%b exp=1", busy); end
        i2c_stop();
        wq();
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rt_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_coherence();
        logic [2:0] acks;
        logic [7:0] d0, d1;
        temp_in = 13'h1E75;
        open_read(8'h00, acks);
        rd_byte(1'b0, d0);
        temp_in = 13'h0190;
        rd_byte(1'b1, d1);
        i2c_stop();
        n_total++; if (d0 !== 8'hF3) begin n_bad++; $display("FAIL coh_msb got=%h exp=f3", d0); end
        n_total++; if (d1 !== 8'hA8) begin n_bad++; $display("FAIL coh_lsb got=%h exp=a8", d1); end
    endtask

    task automatic test_config();
        logic [2:0] acks;
        logic       a0, a1, a2;
        logic [7:0] d;
        i2c_start();
        wr_byte(8'h96, -1, a0);
        wr_byte(8'h03, -1, a1);
        wr_byte(8'hA0, -1, a2);
        i2c_stop();
        n_total++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL cfg_wr_acks got=%b exp=000", {a0, a1, a2}); end
        n_total++; if (cfg_reg !== 8'hA0) begin n_bad++; $display("FAIL cfg_wr got=%h exp=a0", cfg_reg); end
        open_read(8'h03, acks);
        rd_byte(1'b1, d);
        i2c_stop();
        n_total++; if (d !== 8'hA0) begin n_bad++; $display("FAIL cfg_rd got=%h exp=a0", d); end
        open_read(8'h0B, acks);
        rd_byte(1'b1, d);
        i2c_stop();
        n_total++; if (d !== 8'hCB) begin n_bad++; $display("FAIL id_rd got=%h exp=cb", d); end
    endtask

    task automatic test_mismatch();
        logic a0, a1;
        drv_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        wr_byte(8'h90, -1, a0);
        wr_byte(8'h03, -1, a1);
        i2c_stop();
        wq();
        n_total++; if (a0 !== 1'b1) begin n_bad++; $display("FAIL mm_ack got=%b exp=1", a0); end
        n_total++; if (drv_seen !== 1'b0) begin n_bad++; $display("FAIL mm_sda_driven got=%b exp=0", drv_seen); end
        n_total++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL mm_busy got=%b exp=0", busy_seen); end
        n_total++; if (cfg_reg !== 8'hA0) begin n_bad++; $display("FAIL mm_cfg got=%h exp=a0", cfg_reg); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] acks;
        logic       a0, a1, a2, a3;
        logic [7:0] exp_d [5];
        logic [7:0] d;
        temp_in = 13'h0190;
        i2c_start();
        wr_byte(8'h96, -1, a0);
        wr_byte(8'h02, -1, a1);
        wr_byte(8'h11, -1, a2);
        wr_byte(8'h77, -1, a3);
        i2c_stop();
        n_total++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_bad++; $display("FAIL b2b_acks got=%b exp=0000", {a0, a1, a2, a3}); end
        n_total++; if (cfg_reg !== 8'h77) begin n_bad++; $display("FAIL b2b_cfg got=%h exp=77", cfg_reg); end
        exp_d[0] = 8'h00; exp_d[1] = 8'h0C; exp_d[2] = 8'h80; exp_d[3] = 8'h00; exp_d[4] = 8'h77;
        open_read(8'h0F, acks);
        for (int i = 0; i < 5; i++) begin
            rd_byte(i == 4, d);
            n_total++; if (d !== exp_d[i]) begin n_bad++; $display("FAIL b2b_wrap_rd%0d got=%h exp=%h", i, d, exp_d[i]); end
        end
        i2c_stop();
    endtask

    task automatic test_reset_mid_read();
        logic [2:0] acks;
        logic       a;
        logic [7:0] d;
        temp_in = 13'h0190;
        open_read(8'h00, acks);
        n_total++; if (sda_drive_low !== 1'b1) begin n_bad++; $display("FAIL rmr_driving got=%b exp=1", sda_drive_low); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_total++; if (sda_drive_low !== 1'b0) begin n_bad++; $display("FAIL rmr_release got=%b exp=0", sda_drive_low); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmr_busy got=%b exp=0", busy); end
        @(negedge clk); reset = 1'b0;
        n_total++; if (cfg_reg !== 8'h00) begin n_bad++; $display("FAIL rmr_cfg got=%h exp=00", cfg_reg); end
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        i2c_start();
        wr_byte(8'h97, -1, a);
        rd_byte(1'b1, d);
        n_total++; if (a !== 1'b0) begin n_bad++; $display("FAIL rmr_next_ack got=%b exp=0", a); end
        n_total++; if (d !== 8'h0C) begin n_bad++; $display("FAIL rmr_next_rd got=%h exp=0c", d); end
        i2c_stop();
    endtask

    task automatic test_glitch();
        logic       a0, a1, a2;
        logic       exp_ack;
        logic [7:0] exp_cfg;
`ifdef GLITCH_FILTER_EN
        exp_ack = 1'b0; exp_cfg = 8'h3C;
`else
        exp_ack = 1'b1; exp_cfg = 8'h00;
`endif
        i2c_start();
        wr_byte(8'h96, -1, a0);
        wr_byte(8'h03, -1, a1);
        wr_byte(8'h3C, 7, a2);
        i2c_stop();
        n_total++; if (a2 !== exp_ack) begin n_bad++; $display("FAIL glitch_ack got=%b exp=%b", a2, exp_ack); end
        n_total++; if (cfg_reg !== exp_cfg) begin n_bad++; $display("FAIL glitch_cfg got=%h exp=%h", cfg_reg, exp_cfg); end
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        drv_seen = 1'b0; busy_seen = 1'b0;
        test_reset();
        test_read_temp();
        test_coherence();
        test_config();
        test_mismatch();
        test_back_to_back();
        test_reset_mid_read();
        test_glitch();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
